// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered reset sequencer.
// Synchronises a raw asynchronous reset and releases NUM_CH active-low
// reset channels one after another (channel 0 first), with an optional
// software re-reset request acknowledged by a one-cycle pulse.
//
// Ports:
//   clk_i     system clock
//   rst_n_i   raw reset, asynchronous active-low
//   sw_req_i  software re-reset request (level, sampled on clk_i)
//   sw_ack_o  one-cycle pulse when a request is accepted
//   rst_n_o   sequenced active-low resets, bit k = channel k
//   busy_o    sequence in progress
//   done_o    all channels released, sequencer idle
//   ch_idx_o  index of the next channel to release
//
// Build option: define RST_SEQ_REV_ASSERT_EN to pull channels low one at a
// time in descending order on an accepted software request instead of all
// together.
module rst_seq_gen #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DLY_WIDTH   = 8,
   parameter int unsigned INIT_DLY    = 40,
   parameter int unsigned STEP_DLY    = 8,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              sw_req_i,
   output logic              sw_ack_o,
   output logic [NUM_CH-1:0] rst_n_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CH_W-1:0]   ch_idx_o
);

   // Static configuration checks
   if (NUM_CH == 0) begin : g_chk_num_ch
      $error("rst_seq_gen: NUM_CH must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("rst_seq_gen: SYNC_STAGES must be >= 2");
   end
   if (DLY_WIDTH == 0 || DLY_WIDTH > 32) begin : g_chk_dly_w
      $error("rst_seq_gen: DLY_WIDTH must be in 1..32");
   end
   if (64'(INIT_DLY) >= (64'd1 << DLY_WIDTH)) begin : g_chk_init
      $error("rst_seq_gen: INIT_DLY does not fit in DLY_WIDTH bits");
   end
   if (64'(STEP_DLY) >= (64'd1 << DLY_WIDTH)) begin : g_chk_step
      $error("rst_seq_gen: STEP_DLY does not fit in DLY_WIDTH bits");
   end

   localparam logic [DLY_WIDTH-1:0] CNT_ONE  = DLY_WIDTH'(1);
   localparam logic [DLY_WIDTH-1:0] INIT_V   = DLY_WIDTH'(INIT_DLY);
   localparam logic [DLY_WIDTH-1:0] STEP_V   = DLY_WIDTH'(STEP_DLY);
   // The counter reloads count down to 0 and act on the following edge, so
   // the power-on and channel-to-channel waits load one less to hit the
   // exact release edges; software-path waits load the full value.
   localparam logic [DLY_WIDTH-1:0] INIT_M1  = DLY_WIDTH'(INIT_DLY - 1);
   localparam logic [DLY_WIDTH-1:0] STEP_M1  = DLY_WIDTH'(STEP_DLY - 1);
   localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(NUM_CH - 1);

`ifdef RST_SEQ_REV_ASSERT_EN
   typedef enum logic [2:0] {SYNC, INIT_WAIT, STEP_WAIT, DONE, ASSERT_SEQ} state_e;
`else
   typedef enum logic [1:0] {SYNC, INIT_WAIT, STEP_WAIT, DONE} state_e;
`endif

   // Reset-deassertion synchroniser
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_rst_n;

   always_comb sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sync_q <= '0;
      else          sync_q <= sync_d;
   end

   assign sync_rst_n = sync_q[SYNC_STAGES-1];

   state_e                 state_q, state_d;
   logic [DLY_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]        ch_idx_q, ch_idx_d;
   logic [NUM_CH-1:0]      rst_n_q, rst_n_d;
   logic                   ack_q, ack_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   rel_c;
`ifdef RST_SEQ_REV_ASSERT_EN
   logic [CH_W-1:0]        asrt_idx_q, asrt_idx_d;
`endif

   // Sequencer state register, held in reset by the synchroniser output
   always_ff @(posedge clk_i or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         state_q    <= SYNC;
         cnt_q      <= '0;
         ch_idx_q   <= '0;
         rst_n_q    <= '0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
`ifdef RST_SEQ_REV_ASSERT_EN
         asrt_idx_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ch_idx_q   <= ch_idx_d;
         rst_n_q    <= rst_n_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef RST_SEQ_REV_ASSERT_EN
         asrt_idx_q <= asrt_idx_d;
`endif
      end
   end

   // Next-state, counter and channel logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ch_idx_d   = ch_idx_q;
      rst_n_d    = rst_n_q;
      ack_d      = 1'b0;
      rel_c      = 1'b0;
`ifdef RST_SEQ_REV_ASSERT_EN
      asrt_idx_d = asrt_idx_q;
`endif

      case (state_q)
         // Being out of reset here means the synchroniser output is high
         SYNC: begin
            if (INIT_DLY == 0) begin
               rel_c = 1'b1;
            end else begin
               cnt_d   = INIT_M1;
               state_d = INIT_WAIT;
            end
         end

         INIT_WAIT, STEP_WAIT: begin
            if (cnt_q == '0) rel_c = 1'b1;
            else             cnt_d = cnt_q - CNT_ONE;
         end

         DONE: begin
            if (sw_req_i) begin
               ack_d    = 1'b1;
               ch_idx_d = '0;
`ifdef RST_SEQ_REV_ASSERT_EN
               rst_n_d[NUM_CH-1] = 1'b0;
               if (NUM_CH == 1) begin
                  cnt_d   = INIT_V;
                  state_d = INIT_WAIT;
               end else begin
                  asrt_idx_d = CH_W'(NUM_CH - 2);
                  cnt_d      = STEP_V;
                  state_d    = ASSERT_SEQ;
               end
`else
               rst_n_d = '0;
               cnt_d   = INIT_V;
               state_d = INIT_WAIT;
`endif
            end
         end

`ifdef RST_SEQ_REV_ASSERT_EN
         // Pull channels low in descending order, one every STEP_DLY+1 cycles
         ASSERT_SEQ: begin
            if (cnt_q == '0) begin
               rst_n_d[asrt_idx_q] = 1'b0;
               if (asrt_idx_q == '0) begin
                  cnt_d   = INIT_V;
                  state_d = INIT_WAIT;
               end else begin
                  asrt_idx_d = asrt_idx_q - CH_W'(1);
                  cnt_d      = STEP_V;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`endif

         default: state_d = SYNC;
      endcase

      // Channel release; a zero step releases every remaining channel at once
      if (rel_c) begin
         if (STEP_DLY == 0) begin
            rst_n_d  = '1;
            ch_idx_d = LAST_CH;
            state_d  = DONE;
         end else begin
            rst_n_d[ch_idx_q] = 1'b1;
            if (ch_idx_q == LAST_CH) begin
               state_d = DONE;
            end else begin
               ch_idx_d = ch_idx_q + CH_W'(1);
               cnt_d    = STEP_M1;
               state_d  = STEP_WAIT;
            end
         end
      end

      // Status lags the state by one edge; an accepted request drops done at once
      done_d = (state_q == DONE) && !ack_d;
      busy_d = !done_d;
   end

   assign sw_ack_o = ack_q;
   assign rst_n_o  = rst_n_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign ch_idx_o = ch_idx_q;

endmodule
